ark_round_ctrl: RTL

- Sequential AddRoundKey stage and round controller for the AES-128 encrypt datapath; sits directly downstream of mc.
- Holds the 128-bit cipher state register and XORs the round key into it:
  - plaintext for round 0,
  - mc output for rounds 1..NR-1,
  - ShiftRows output for the final round, which bypasses MixColumns.
- Drives mc_enable and the round number to the rest of the datapath. Presents the ciphertext on a valid/ready output handshake.

---
 rtl/ark_round_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ark_round_ctrl.sv
// ---------------------------------------------------------------------------
// ark_round_ctrl
// AddRoundKey stage and round controller of the AES-128 encrypt datapath.
// Owns the 128-bit cipher state register. Each round it XORs the current round
// key into one of three sources:
//   - the latched plaintext (round 0),
//   - the MixColumns output (rounds 1..NR-1),
//   - the ShiftRows output (final round, MixColumns bypassed).
// It also sequences the round number and presents the ciphertext on a
// valid/ready handshake.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_start       begin a block; only looked at in IDLE
//   i_plaintext   input block, byte 0 in [127:120]
//   i_sr_data     SubBytes+ShiftRows of o_state_q (from upstream)
//   i_mc_data     MixColumns of i_sr_data (from mc)
//   i_round_key   round key for o_round
//   i_key_valid   i_round_key usable this cycle; low stalls the round
//   o_state_q     current cipher state
//   o_round       current round number 0..NR
//   o_mc_enable   enable for mc, high in RUN for rounds below NR
//   o_busy        high whenever the controller is not IDLE
//   o_ct_valid    ciphertext valid
//   o_ciphertext  result block, stable while o_ct_valid
//   i_ct_ready    consumer accepts the ciphertext
// NR must lie in 1..15 so that the 4-bit round counter never wraps.
// ---------------------------------------------------------------------------
module ark_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_plaintext,
  input  logic [127:0] i_sr_data,
  input  logic [127:0] i_mc_data,
  input  logic [127:0] i_round_key,
  input  logic         i_key_valid,
  output logic [127:0] o_state_q,
  output logic [3:0]   o_round,
  output logic         o_mc_enable,
  output logic         o_busy,
  output logic         o_ct_valid,
  output logic [127:0] o_ciphertext,
  input  logic         i_ct_ready
);

  localparam logic [3:0] LP_NR = 4'(NR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [127:0] r_state_q;
  logic [127:0] r_pt_q;
  logic [127:0] r_ct;
  logic [3:0]   r_round;
  logic         r_ct_valid;
  logic         w_last_round;
  logic [127:0] w_final_state;

  assign w_last_round  = (r_round == LP_NR);
  // Final round skips MixColumns, so the key is added to the ShiftRows result.
  assign w_final_state = i_sr_data ^ i_round_key;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE: begin
        if (i_start) w_fsm_nxt = ST_LOAD;
        else         w_fsm_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (i_key_valid) w_fsm_nxt = ST_RUN;
        else             w_fsm_nxt = ST_LOAD;
      end
      ST_RUN: begin
        if (i_key_valid && w_last_round) w_fsm_nxt = ST_OUT;
        else                             w_fsm_nxt = ST_RUN;
      end
      ST_OUT: begin
        if (i_ct_ready) w_fsm_nxt = ST_IDLE;
        else            w_fsm_nxt = ST_OUT;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    o_busy      = 1'b0;
    o_mc_enable = 1'b0;
    if (r_fsm != ST_IDLE) o_busy = 1'b1;
    else                  o_busy = 1'b0;
    // mc is only needed for rounds that actually use MixColumns.
    if ((r_fsm == ST_RUN) && (r_round < LP_NR)) o_mc_enable = 1'b1;
    else                                         o_mc_enable = 1'b0;
  end

  // Datapath: plaintext latch, cipher state, round counter, ciphertext
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pt_q     <= 128'd0;
      r_state_q  <= 128'd0;
      r_ct       <= 128'd0;
      r_round    <= 4'd0;
      r_ct_valid <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (i_start) begin
            r_pt_q  <= i_plaintext;
            r_round <= 4'd0;
          end
        end
        ST_LOAD: begin
          if (i_key_valid) begin
            r_state_q <= r_pt_q ^ i_round_key;
            r_round   <= 4'd1;
          end
        end
        ST_RUN: begin
          // With key_valid low every register simply holds (stall).
          if (i_key_valid) begin
            if (w_last_round) begin
              r_state_q  <= w_final_state;
              r_ct       <= w_final_state;
              r_ct_valid <= 1'b1;
            end else begin
              r_state_q <= i_mc_data ^ i_round_key;
              r_round   <= r_round + 4'd1;
            end
          end
        end
        ST_OUT: begin
          if (i_ct_ready) begin
            r_ct_valid <= 1'b0;
            r_round    <= 4'd0;
          end
        end
        default: begin
          r_ct_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_state_q    = r_state_q;
  assign o_round      = r_round;
  assign o_ct_valid   = r_ct_valid;
  assign o_ciphertext = r_ct;

endmodule
